jt10_adpcm_div_arb: RTL and testbench

- Shares one unsigned serial restoring divider between N requesters.
- Requesters are the ADPCM-B interpolator step computation and the ADPCM-A per-channel scaling paths.
- Arbitration is round-robin. The winner's operands are latched, one quotient bit is resolved per cen, and quotient and remainder are returned with a per-requester done pulse.
- Sits between the ADPCM decoders and the divider datapath, replacing per-requester divider instances.

---
 rtl/jt10_adpcm_div_arb_if.sv | 25 ++
 rtl/jt10_adpcm_div_arb.sv | 130 +++++++++++++
 tb/tb_jt10_adpcm_div_arb.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jt10_adpcm_div_arb_if.sv
// Request/result bundle between the ADPCM requesters and the shared divider.
// Master is the requester side; slave is the arbitrated divider.
interface jt10_adpcm_div_arb_if #(
    parameter int N  = 4,
    parameter int DW = 16
) ();
    logic [N-1:0]    req;
    logic [N*DW-1:0] a;
    logic [N*DW-1:0] b;
    logic [N-1:0]    ack;
    logic [N-1:0]    done;
    logic [DW-1:0]   d;
    logic [DW-1:0]   r;
    logic            busy;

    modport master (
        output req, a, b,
        input  ack, done, d, r, busy
    );

    modport slave (
        input  req, a, b,
        output ack, done, d, r, busy
    );
endinterface

// File: rtl/jt10_adpcm_div_arb.sv
// Round-robin arbiter in front of one unsigned serial restoring divider,
// resolving one quotient bit per cen and returning d/r with a done pulse.
module jt10_adpcm_div_arb #(
    parameter int N  = 4,
    parameter int DW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cen,
    jt10_adpcm_div_arb_if.slave  bus
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(DW + 1);

    typedef enum logic {IDLE, DIV} state_t;

    state_t          state, state_n;
    logic [PW-1:0]   ptr, ptr_n, idx, idx_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [DW-1:0]   opa, opa_n, opb, opb_n, rem, rem_n;
    logic [DW-1:0]   d_q, d_n, r_q, r_n;
    logic [N-1:0]    ack_q, ack_n, done_q, done_n;
    logic            busy_q, busy_n;

    logic            found;
    logic [PW-1:0]   pick;
    logic [DW:0]     shifted, trial;
    logic            qbit;

    // First requesting index at or after ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        for (int k = 0; k < N; k++) begin
            if (!found && bus.req[(int'(ptr) + k) % N]) begin
                found = 1'b1;
                pick  = PW'((int'(ptr) + k) % N);
            end
        end
    end

    // opa doubles as the dividend shifter and the quotient accumulator:
    // dividend bits leave at the top while quotient bits enter at the bottom.
    always_comb begin
        shifted = {rem, opa[DW-1]};
        trial   = shifted - {1'b0, opb};
        qbit    = ~trial[DW];
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        idx_n   = idx;
        cnt_n   = cnt;
        opa_n   = opa;
        opb_n   = opb;
        rem_n   = rem;
        d_n     = d_q;
        r_n     = r_q;
        busy_n  = busy_q;
        ack_n   = '0;
        done_n  = '0;
        if (cen) begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state_n    = DIV;
                        idx_n      = pick;
                        ptr_n      = (int'(pick) == N - 1) ? '0 : pick + 1'b1;
                        opa_n      = bus.a[int'(pick)*DW +: DW];
                        opb_n      = bus.b[int'(pick)*DW +: DW];
                        rem_n      = '0;
                        cnt_n      = '0;
                        ack_n[pick] = 1'b1;
                        busy_n     = 1'b1;
                    end
                end
                DIV: begin
                    rem_n = qbit ? trial[DW-1:0] : shifted[DW-1:0];
                    opa_n = {opa[DW-2:0], qbit};
                    cnt_n = cnt + 1'b1;
                    if (cnt == CW'(DW - 1)) begin
                        d_n         = opa_n;
                        r_n         = rem_n;
                        done_n[idx] = 1'b1;
                        busy_n      = 1'b0;
                        state_n     = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= '0;
            idx    <= '0;
            cnt    <= '0;
            opa    <= '0;
            opb    <= '0;
            rem    <= '0;
            d_q    <= '0;
            r_q    <= '0;
            ack_q  <= '0;
            done_q <= '0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_n;
            ptr    <= ptr_n;
            idx    <= idx_n;
            cnt    <= cnt_n;
            opa    <= opa_n;
            opb    <= opb_n;
            rem    <= rem_n;
            d_q    <= d_n;
            r_q    <= r_n;
            ack_q  <= ack_n;
            done_q <= done_n;
            busy_q <= busy_n;
        end
    end

    assign bus.ack  = ack_q;
    assign bus.done = done_q;
    assign bus.d    = d_q;
    assign bus.r    = r_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_jt10_adpcm_div_arb.sv
// Bench for jt10_adpcm_div_arb: directed scenarios plus randomized traffic,
// all outputs compared each cycle against a transaction-level model.
module tb_jt10_adpcm_div_arb;
    localparam int N  = 4;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cen = 1'b1;
    int   cen_div = 1;
    int   ncyc = 0;
    int   pcnt = 0;
    bit   chk_en = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    jt10_adpcm_div_arb_if #(.N(N), .DW(DW)) bus ();

    jt10_adpcm_div_arb #(.N(N), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .cen (cen),
        .bus (bus)
    );

    always @(posedge clk) pcnt++;

    // cen is high on one clk out of every cen_div
    always @(negedge clk) begin
        ncyc++;
        cen = ((ncyc % cen_div) == 0);
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: an op finishes DW cen edges after its grant
    // with the arithmetic quotient/remainder (b=0 gives all ones and a).
    logic [N-1:0]  e_ack, e_done;
    logic [DW-1:0] e_d, e_r;
    logic          e_busy;
    int            m_ptr, m_idx, m_left, m_sel;
    bit            m_active;
    logic [DW-1:0] m_a, m_b;

    always @(posedge clk) begin
        if (rst) begin
            e_ack = '0; e_done = '0; e_d = '0; e_r = '0; e_busy = 1'b0;
            m_ptr = 0; m_active = 1'b0; m_left = 0;
        end else begin
            e_ack  = '0;
            e_done = '0;
            if (cen) begin
                if (m_active) begin
                    m_left--;
                    if (m_left == 0) begin
                        if (m_b == '0) begin
                            e_d = '1;
                            e_r = m_a;
                        end else begin
                            e_d = m_a / m_b;
                            e_r = m_a % m_b;
                        end
                        e_done[m_idx] = 1'b1;
                        e_busy   = 1'b0;
                        m_active = 1'b0;
                    end
                end else if (bus.req != '0) begin
                    m_sel = -1;
                    for (int k = 0; k < N; k++)
                        if (m_sel < 0 && bus.req[(m_ptr + k) % N]) m_sel = (m_ptr + k) % N;
                    m_idx = m_sel;
                    m_a   = bus.a[m_sel*DW +: DW];
                    m_b   = bus.b[m_sel*DW +: DW];
                    e_ack[m_sel] = 1'b1;
                    e_busy   = 1'b1;
                    m_left   = DW;
                    m_active = 1'b1;
                    m_ptr    = (m_sel + 1) % N;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check_output("cyc_ack",  bus.ack,  e_ack);
            check_output("cyc_done", bus.done, e_done);
            check_output("cyc_busy", bus.busy, e_busy);
            check_output("cyc_d",    bus.d,    e_d);
            check_output("cyc_r",    bus.r,    e_r);
        end
    end

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) if (v[k]) return k;
        return -1;
    endfunction

    task automatic wait_pulse(input bit want_done, input int idx, input int budget,
                              input string name, output int at);
        at = -1;
        for (int t = 0; t < budget; t++) begin
            @(posedge clk); #1;
            if (want_done ? bus.done[idx] : bus.ack[idx]) begin
                at = pcnt;
                break;
            end
        end
        if (at < 0) check_output({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic apply_stimulus(input int idx, input logic [DW-1:0] av, input logic [DW-1:0] bv);
        bus.a[idx*DW +: DW] = av;
        bus.b[idx*DW +: DW] = bv;
        bus.req[idx] = 1'b1;
    endtask

    task automatic run_op(input int idx, input logic [DW-1:0] av, input logic [DW-1:0] bv,
                          input logic [DW-1:0] ed, input logic [DW-1:0] er, input string name);
        int t_ack, t_done;
        @(negedge clk);
        apply_stimulus(idx, av, bv);
        wait_pulse(1'b0, idx, 200, {name, "_ack"}, t_ack);
        bus.req[idx] = 1'b0;
        check_output({name, "_busy_on"}, bus.busy, 1);
        @(posedge clk); #1;
        check_output({name, "_ack_width"}, bus.ack, 0);
        wait_pulse(1'b1, idx, 400, {name, "_done"}, t_done);
        check_output({name, "_latency"}, t_done - t_ack, DW * cen_div);
        check_output({name, "_d"}, bus.d, ed);
        check_output({name, "_r"}, bus.r, er);
        check_output({name, "_busy_off"}, bus.busy, 0);
        @(posedge clk); #1;
        check_output({name, "_done_width"}, bus.done, 0);
    endtask

    task automatic apply_reset(input logic [N-1:0] rq);
        @(negedge clk);
        rst = 1'b1;
        bus.req = rq;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // order holds the expected grant indices, one nibble each, first grant lowest
    task automatic collect(input logic [N-1:0] rq, input logic [15:0] order, input string name);
        int id;
        bus.req = rq;
        for (int g = 0; g < 4; g++) begin
            id = -1;
            for (int t = 0; t < 200; t++) begin
                @(posedge clk); #1;
                if (|bus.ack) begin
                    id = oh_idx(bus.ack);
                    break;
                end
            end
            check_output($sformatf("%s_grant%0d", name, g), id, 32'(order[4*g +: 4]));
        end
        bus.req = '0;
        for (int t = 0; t < 100; t++) begin
            @(posedge clk); #1;
            if (!bus.busy) break;
        end
        check_output({name, "_idle"}, bus.busy, 0);
    endtask

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int t_ack0, t_done0, t_ack2, t_x;
        bus.req = '0;
        bus.a   = '0;
        bus.b   = '0;
        rst     = 1'b1;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check_output("rst_ack",  bus.ack,  0);
        check_output("rst_done", bus.done, 0);
        check_output("rst_d",    bus.d,    0);
        check_output("rst_r",    bus.r,    0);
        check_output("rst_busy", bus.busy, 0);
        rst = 1'b0;

        run_op(1, 16'd100,  16'd7,   16'd14,   16'd2,    "op100_7");
        run_op(2, 16'h1234, 16'h0,   16'hFFFF, 16'h1234, "div0");
        run_op(0, 16'd5,    16'd9,   16'd0,    16'd5,    "a_lt_b");
        run_op(1, 16'hFFFF, 16'd1,   16'hFFFF, 16'd0,    "ffff_1");

        apply_reset(4'b0101);
        collect(4'b0101, 16'h2020, "rr0101");

        run_op(3, 16'h4321, 16'h4321, 16'd1, 16'd0, "a_eq_b");
        collect(4'b1111, 16'h3210, "rr1111");

        cen_div = 4;
        run_op(0, 16'd1000, 16'd10, 16'd100, 16'd0, "cen_gate");
        cen_div = 1;
        @(negedge clk);

        // abort requester 1 at step 8, then requester 3 must win straight away
        apply_stimulus(1, 16'd500, 16'd3);
        wait_pulse(1'b0, 1, 200, "abort_ack", t_x);
        bus.req[1] = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        apply_stimulus(3, 16'hFFFF, 16'd1);
        @(posedge clk); #1;
        check_output("abort_ack_in_rst", bus.ack,  0);
        check_output("abort_done",       bus.done, 0);
        check_output("abort_d",          bus.d,    0);
        check_output("abort_r",          bus.r,    0);
        check_output("abort_busy",       bus.busy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check_output("abort_regrant", bus.ack, 4'b1000);
        bus.req[3] = 1'b0;
        wait_pulse(1'b1, 3, 100, "abort_next_done", t_x);
        check_output("abort_next_d", bus.d, 16'hFFFF);
        check_output("abort_next_r", bus.r, 16'd0);

        // requester 2 arrives mid-op and is served right after requester 0
        @(negedge clk);
        apply_stimulus(0, 16'd200, 16'd9);
        wait_pulse(1'b0, 0, 200, "wait0_ack", t_ack0);
        bus.req[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        apply_stimulus(2, 16'd1000, 16'd7);
        wait_pulse(1'b1, 0, 100, "wait0_done", t_done0);
        check_output("wait0_d", bus.d, 16'd22);
        check_output("wait0_r", bus.r, 16'd2);
        wait_pulse(1'b0, 2, 10, "wait2_ack", t_ack2);
        check_output("wait2_gap", t_ack2 - t_done0, 1);
        bus.req[2] = 1'b0;
        bus.a[2*DW +: DW] = 16'd0;
        bus.b[2*DW +: DW] = 16'd1;
        wait_pulse(1'b1, 2, 100, "wait2_done", t_x);
        check_output("wait2_d", bus.d, 16'd142);
        check_output("wait2_r", bus.r, 16'd6);

        // randomized traffic, the per-cycle compare does the checking
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (t % 500 == 0) cen_div = $urandom_range(1, 3);
            rst = ($urandom_range(0, 199) == 0);
            bus.req = N'($urandom);
            for (int k = 0; k < N; k++) begin
                bus.a[k*DW +: DW] = DW'($urandom);
                case ($urandom_range(0, 3))
                    0:       bus.b[k*DW +: DW] = '0;
                    1:       bus.b[k*DW +: DW] = DW'($urandom_range(1, 15));
                    2:       bus.b[k*DW +: DW] = bus.a[k*DW +: DW];
                    default: bus.b[k*DW +: DW] = DW'($urandom);
                endcase
            end
        end
        @(negedge clk);
        rst = 1'b0;
        bus.req = '0;
        cen_div = 1;
        repeat (40) @(negedge clk);
        check_output("final_idle", bus.busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
